ah_rr_requester_8: RTL and testbench
====================================

Name: ah_rr_requester_8

Overview:
- Requester-side front end for the 8-way round-robin arbiter.
- Each of 8 client channels posts jobs. The block queues a per-channel pending count, drives the arbiter `req` vector, and consumes the one-hot `gnt` pulses.
- On each grant the channel holds bus ownership for a fixed burst, then either re-requests or goes idle.
- Sits between the client engines and the arbiter; checks `gnt` legality.

Parameters:
- NUM_CH, 8, number of channels; fixed at 8 to match the arbiter width.
- BURST_LEN, 4, ownership cycles per grant; legal range 1..16.
- PEND_W, 2, per-channel pending counter width; max pending jobs = 2^PEND_W-1 = 3.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- job_push  in  8  per-channel job post pulse; one job per set bit per cycle.
- gnt  in  8  grant pulse vector from the arbiter; expected one-hot or zero.
- req  out  8  request vector to the arbiter.
- own  out  8  channel currently owns the bus (burst in progress).
- beat_last  out  8  high on the final ownership cycle of a burst.
- pend_full  out  8  channel pending count at maximum.
- push_ovf  out  1  pulse: a push was dropped because its channel was full.
- err_gnt  out  1  pulse: illegal gnt seen.
- busy  out  1  any channel has pending jobs or ownership.

Behaviour:

One clock; reset is synchronous and active-high.

Reset (rst=1 at an edge):
- All pending counts, beat counters and own bits clear.
- All outputs 0 from the next cycle.
- Reset mid-burst aborts the burst; no beat_last is issued.
- rst has priority over push and gnt in the same cycle.

Per-channel state, derived from registers:
- IDLE: pend==0, own==0.
- WAIT: pend>0, own==0.
- OWN: own==1; the pend value is independent of this state.

Request output:
- req[i] = (pend[i]!=0) & ~own[i], combinational from registers.
- No combinational path from gnt or job_push to req.

Push:
- job_push[i] at edge t increments pend[i], visible in cycle t+1; req[i] rises in t+1 if not owning.
- Push while pend[i]==max: job dropped, pend unchanged, push_ovf=1 in cycle t+1.
- Push and accepted grant on the same channel in the same cycle: pend net unchanged.

Grant legality, checked in cycle t:
- gnt is legal iff it is zero, or it is one-hot AND req[gnt bit]==1.
- Illegal gnt (multi-hot, or a bit set on a non-requesting channel): the whole vector is ignored and err_gnt=1 in cycle t+1. Pends and owns are unchanged by gnt.

Accepted grant on channel i, sampled at edge t:
- pend[i] decrements.
- own[i]=1 for cycles t+1 .. t+BURST_LEN.
- Beat counter loads BURST_LEN-1 and decrements each owned cycle.
- beat_last[i]=1 when the counter reaches 0, i.e. in cycle t+BURST_LEN.
- own[i] clears at the end of that cycle.
- If pend[i]>0 after the burst, req[i] rises in cycle t+BURST_LEN+1; otherwise the channel returns to IDLE.
- BURST_LEN=1: own and beat_last are both high for the single cycle t+1.

Cross-channel:
- Ownership on different channels may overlap; the block does not serialize bursts. Overlap is legal.

Other outputs:
- pend_full[i] = (pend[i]==max), registered-derived.
- busy = OR over all channels of (pend!=0 | own).
- push_ovf and err_gnt are single-cycle pulses, one per offending cycle (not per channel).

Test Plan:
- Reset: rst=1 for 2 cycles with job_push=8'hFF -> after release, req=0, own=0, busy=0, no ovf.
- Single job, BURST_LEN=4:
  - job_push=8'h04 at cycle 0 -> req=8'h04 in cycle 1.
  - gnt=8'h04 in cycle 3 -> req=0 and own=8'h04 in cycles 4-7; beat_last=8'h04 in cycle 7; busy=0 in cycle 8.
- Back-to-back and overflow: push ch0 on 4 consecutive cycles.
  - pend_full[0] set after the 3rd push; 4th push dropped with push_ovf=1.
  - Three grants each yield 4-cycle bursts; req[0] re-rises the cycle after each beat_last, and is 0 after the 3rd burst.
- Simultaneous push and grant on ch5 with pend=1 -> pend stays 1, own[5]=1, and req[5]=1 again after beat_last.
- Illegal grants:
  - gnt=8'h03 with req=8'h03 -> err_gnt=1 next cycle, own=0, pends unchanged.
  - gnt=8'h10 with req[4]=0 -> err_gnt=1, ignored.
- Reset mid-burst: rst=1 in 2nd own cycle -> own=0, beat_last never asserted, pend=0.

Source files
------------

// File: rtl/ah_rr_requester_8.sv
// Requester front end for the 8-way round-robin arbiter.
// Queues per-channel jobs, drives req, and runs fixed-length bursts on grant.
module ah_rr_requester_8 #(
  parameter int NUM_CH    = 8,
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] job_push,
  input  logic [NUM_CH-1:0] gnt,
  output logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] own,
  output logic [NUM_CH-1:0] beat_last,
  output logic [NUM_CH-1:0] pend_full,
  output logic              push_ovf,
  output logic              err_gnt,
  output logic              busy
);

  localparam int BW = 4;
  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [BW-1:0] BLOAD = BW'(BURST_LEN - 1);

  logic [PEND_W-1:0] pend_q [NUM_CH];
  logic [PEND_W-1:0] pend_d [NUM_CH];
  logic [BW-1:0]     beat_q [NUM_CH];
  logic [BW-1:0]     beat_d [NUM_CH];
  logic [NUM_CH-1:0] own_q;
  logic [NUM_CH-1:0] own_d;
  logic [NUM_CH-1:0] nz;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] acc_gnt;
  logic [NUM_CH-1:0] acc_push;
  logic              gnt_onehot;
  logic              gnt_legal;
  logic              ovf_q;
  logic              err_q;

  always_comb begin
    nz        = '0;
    full      = '0;
    beat_last = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      nz[i]        = pend_q[i] != '0;
      full[i]      = pend_q[i] == PMAX;
      beat_last[i] = own_q[i] && (beat_q[i] == '0);
    end
  end

  assign req       = nz & ~own_q;
  assign own       = own_q;
  assign pend_full = full;
  assign busy      = |(nz | own_q);
  assign push_ovf  = ovf_q;
  assign err_gnt   = err_q;

  // An illegal vector is dropped as a whole, never partially applied
  assign gnt_onehot = (gnt != '0) &&
                      ((gnt & (gnt - NUM_CH'(1))) == '0);
  assign gnt_legal  = (gnt == '0) ||
                      (gnt_onehot && ((gnt & req) != '0));
  assign acc_gnt    = gnt_legal ? gnt : '0;
  assign acc_push   = job_push & ~full;

  always_comb begin
    own_d = own_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pend_d[i] = pend_q[i] + PEND_W'(acc_push[i])
                            - PEND_W'(acc_gnt[i]);
      beat_d[i] = beat_q[i];
      if (acc_gnt[i]) begin
        own_d[i]  = 1'b1;
        beat_d[i] = BLOAD;
      end else if (own_q[i]) begin
        if (beat_q[i] == '0) own_d[i] = 1'b0;
        else beat_d[i] = beat_q[i] - BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_q[i] <= '0;
        beat_q[i] <= '0;
      end
    end else begin
      own_q <= own_d;
      ovf_q <= |(job_push & full);
      err_q <= ~gnt_legal;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_q[i] <= pend_d[i];
        beat_q[i] <= beat_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ah_rr_requester_8.sv
// Directed bench for ah_rr_requester_8.
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_ah_rr_requester_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] job_push;
  logic [7:0] gnt;
  logic [7:0] req;
  logic [7:0] own;
  logic [7:0] beat_last;
  logic [7:0] pend_full;
  logic       push_ovf;
  logic       err_gnt;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  ah_rr_requester_8 dut (
    .clk       (clk),
    .rst       (rst),
    .job_push  (job_push),
    .gnt       (gnt),
    .req       (req),
    .own       (own),
    .beat_last (beat_last),
    .pend_full (pend_full),
    .push_ovf  (push_ovf),
    .err_gnt   (err_gnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [7:0] e_req,
                         input logic [7:0] e_own,
                         input logic [7:0] e_bl,
                         input logic e_busy);
    chk({tag, ".req"}, req, e_req);
    chk({tag, ".own"}, own, e_own);
    chk({tag, ".beat_last"}, beat_last, e_bl);
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
  endtask

  initial begin
    rst = 1'b1; job_push = 8'hFF; gnt = 8'h00;
    tick(); tick();
    rst = 1'b0; job_push = 8'h00;
    chk_all("rst", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("rst.ovf", {7'd0, push_ovf}, 8'h00);
    chk("rst.full", pend_full, 8'h00);
    tick();
    chk_all("rst_idle", 8'h00, 8'h00, 8'h00, 1'b0);

    // single job on ch2
    job_push = 8'h04;
    tick();
    job_push = 8'h00;
    chk_all("c1", 8'h04, 8'h00, 8'h00, 1'b1);
    tick(); tick();
    gnt = 8'h04;
    tick();
    gnt = 8'h00;
    chk_all("c4", 8'h00, 8'h04, 8'h00, 1'b1);
    chk("c4.err", {7'd0, err_gnt}, 8'h00);
    tick();
    chk_all("c5", 8'h00, 8'h04, 8'h00, 1'b1);
    tick();
    chk_all("c6", 8'h00, 8'h04, 8'h00, 1'b1);
    tick();
    chk_all("c7", 8'h00, 8'h04, 8'h04, 1'b1);
    tick();
    chk_all("c8", 8'h00, 8'h00, 8'h00, 1'b0);

    // overflow on ch0
    job_push = 8'h01;
    tick(); chk("p1.full", pend_full, 8'h00);
    tick(); chk("p2.full", pend_full, 8'h00);
    tick(); chk("p3.full", pend_full, 8'h01);
    chk("p3.ovf", {7'd0, push_ovf}, 8'h00);
    tick(); chk("p4.full", pend_full, 8'h01);
    chk("p4.ovf", {7'd0, push_ovf}, 8'h01);
    job_push = 8'h00;
    tick();
    chk("p5.ovf", {7'd0, push_ovf}, 8'h00);
    chk("p5.req", req, 8'h01);
    for (int k = 0; k < 3; k++) begin
      gnt = 8'h01;
      tick();
      gnt = 8'h00;
      chk_all("b_o1", 8'h00, 8'h01, 8'h00, 1'b1);
      chk("b_o1.full", pend_full, 8'h00);
      tick(); tick(); tick();
      chk_all("b_o4", 8'h00, 8'h01, 8'h01, 1'b1);
      tick();
      chk_all("b_after", (k < 2) ? 8'h01 : 8'h00, 8'h00,
              8'h00, k < 2);
    end

    // push and grant together on ch5
    job_push = 8'h20;
    tick();
    chk("s.req", req, 8'h20);
    gnt = 8'h20;
    tick();
    job_push = 8'h00; gnt = 8'h00;
    chk_all("s_o1", 8'h00, 8'h20, 8'h00, 1'b1);
    tick(); tick(); tick();
    chk_all("s_o4", 8'h00, 8'h20, 8'h20, 1'b1);
    tick();
    chk_all("s_after", 8'h20, 8'h00, 8'h00, 1'b1);
    gnt = 8'h20;
    tick();
    gnt = 8'h00;
    tick(); tick(); tick(); tick();
    chk_all("s_drain", 8'h00, 8'h00, 8'h00, 1'b0);

    // illegal grants
    job_push = 8'h03;
    tick();
    job_push = 8'h00;
    chk("i.req", req, 8'h03);
    gnt = 8'h03;
    tick();
    gnt = 8'h00;
    chk("i_mh.err", {7'd0, err_gnt}, 8'h01);
    chk_all("i_mh", 8'h03, 8'h00, 8'h00, 1'b1);
    tick();
    chk("i_clr.err", {7'd0, err_gnt}, 8'h00);
    gnt = 8'h10;
    tick();
    gnt = 8'h00;
    chk("i_nr.err", {7'd0, err_gnt}, 8'h01);
    chk_all("i_nr", 8'h03, 8'h00, 8'h00, 1'b1);

    // legal grant, then reset in its 2nd owned cycle
    gnt = 8'h01;
    tick();
    gnt = 8'h00;
    chk("l.err", {7'd0, err_gnt}, 8'h00);
    chk_all("l_o1", 8'h02, 8'h01, 8'h00, 1'b1);
    tick();
    chk_all("l_o2", 8'h02, 8'h01, 8'h00, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("r_mid", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("r_mid.full", pend_full, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("r_after", 8'h00, 8'h00, 8'h00, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
